// File: rtl/dkong_snd_cmd_if.sv
// Sound-command FIFO, trigger pulse stretcher and DAC register between main CPU and i8035 MCU.
// Latency: flags, O_DB, O_TRIG_N and O_DAC are all registered, 1 cycle from sampled inputs.
// Backpressure: O_CMD_FULL warns the writer; a push while full (no same-cycle pop) is dropped and sets sticky O_OVF.
// Optional macro DKONG_SND_DAC_SLEW_EN: O_DAC slews toward I_DAC by at most SLEW_STEP per cycle.
module dkong_snd_cmd_if #(
  parameter int CMD_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TRIG_N     = 3,
  parameter int STRETCH    = 16,
  parameter int SLEW_STEP  = 4
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic [CMD_W-1:0]  I_CMD_DAT,
  input  logic              I_CMD_WE,
  output logic              O_CMD_FULL,
  output logic              O_OVF,
  input  logic              I_OVF_CLR,
  input  logic [TRIG_N-1:0] I_TRIG,
  output logic [TRIG_N-1:0] O_TRIG_N,
  input  logic              I_RD_N,
  input  logic              I_RD_SEL,
  output logic [7:0]        O_DB,
  output logic              O_INT_N,
  input  logic [7:0]        I_DAC,
  output logic [7:0]        O_DAC
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             rd_n_q;
  logic [TRIG_N-1:0] trig_q;
  logic [7:0]       cnt [TRIG_N];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic ovf_set;
  logic [CMD_W-1:0] head_inv;

  // Pop on the release edge of the MCU read strobe; a pop frees a slot for a same-cycle push.
  always_comb begin
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    pop        = ~rd_n_q & I_RD_N & I_RD_SEL & ~empty;
    push       = I_CMD_WE & (~full | pop);
    ovf_set    = I_CMD_WE & full & ~pop;
    head_inv   = ~mem[rd_ptr];
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Command storage; contents need no reset because count gates every read.
  always_ff @(posedge I_CLK) begin
    if (I_RST && push) begin
      mem[wr_ptr] <= I_CMD_DAT;
    end
  end

  // FIFO pointers, occupancy and the flags derived from the post-update occupancy.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      O_CMD_FULL <= 1'b0;
      O_INT_N    <= 1'b1;
      O_OVF      <= 1'b0;
      rd_n_q     <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      O_CMD_FULL <= (count_next == FULL_CNT);
      O_INT_N    <= (count_next == '0);
      // A new overflow outranks a clear arriving in the same cycle.
      if (ovf_set) begin
        O_OVF <= 1'b1;
      end else if (I_OVF_CLR) begin
        O_OVF <= 1'b0;
      end
      rd_n_q <= I_RD_N;
    end
  end

  // MCU bus contribution: inverted head during a selected read, all-ones when empty, else 0 for OR-ing.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      O_DB <= 8'h00;
    end else if (I_RD_SEL && !I_RD_N) begin
      O_DB <= empty ? 8'({CMD_W{1'b1}}) : 8'(head_inv);
    end else begin
      O_DB <= 8'h00;
    end
  end

  // Per-channel pulse stretcher: a rising edge (re)loads the counter, output low while raw high or counting.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      trig_q   <= '0;
      O_TRIG_N <= '1;
      for (int i = 0; i < TRIG_N; i++) begin
        cnt[i] <= 8'd0;
      end
    end else begin
      trig_q <= I_TRIG;
      for (int i = 0; i < TRIG_N; i++) begin
        O_TRIG_N[i] <= ~(I_TRIG[i] | (cnt[i] != 8'd0));
        if (I_TRIG[i] && !trig_q[i]) begin
          cnt[i] <= 8'(STRETCH);
        end else if (cnt[i] != 8'd0) begin
          cnt[i] <= cnt[i] - 8'd1;
        end
      end
    end
  end

`ifdef DKONG_SND_DAC_SLEW_EN
  logic [8:0] dac_cur9;
  logic [8:0] dac_in9;
  logic [8:0] step9;

  always_comb begin
    dac_cur9 = {1'b0, O_DAC};
    dac_in9  = {1'b0, I_DAC};
    step9    = 9'(SLEW_STEP);
  end

  // Slew-limited DAC: move by at most step9, landing exactly on the target when within reach.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      O_DAC <= 8'h00;
    end else if (dac_in9 > dac_cur9) begin
      O_DAC <= ((dac_in9 - dac_cur9) <= step9) ? I_DAC : 8'(dac_cur9 + step9);
    end else if (dac_in9 < dac_cur9) begin
      O_DAC <= ((dac_cur9 - dac_in9) <= step9) ? I_DAC : 8'(dac_cur9 - step9);
    end
  end
`else
  // Plain DAC register, one cycle behind the MCU port.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      O_DAC <= 8'h00;
    end else begin
      O_DAC <= I_DAC;
    end
  end
`endif

endmodule

// File: tb/tb_dkong_snd_cmd_if.sv
// Self-checking bench for dkong_snd_cmd_if: directed test-plan steps plus a random phase,
// compared every cycle against a queue-based reference model.
module tb_dkong_snd_cmd_if;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cmd;
  logic       we;
  logic       o_full;
  logic       o_ovf;
  logic       ovf_clr;
  logic [2:0] trig;
  logic [2:0] o_trig_n;
  logic       rd_n;
  logic       rd_sel;
  logic [7:0] o_db;
  logic       o_int_n;
  logic [7:0] dac;
  logic [7:0] o_dac;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [3:0] q[$];
  logic       m_ovf, m_full, m_int_n;
  logic [7:0] m_db;
  logic [2:0] m_trig_n;
  int         m_dac;
  logic       prev_rd_n;
  logic [2:0] prev_trig;
  int         last_rise [3];
  int         cyc = 0;

  dkong_snd_cmd_if #(
    .CMD_W(4), .FIFO_DEPTH(4), .TRIG_N(3), .STRETCH(16), .SLEW_STEP(4)
  ) dut (
    .I_CLK(clk), .I_RST(rst), .I_CMD_DAT(cmd), .I_CMD_WE(we),
    .O_CMD_FULL(o_full), .O_OVF(o_ovf), .I_OVF_CLR(ovf_clr),
    .I_TRIG(trig), .O_TRIG_N(o_trig_n), .I_RD_N(rd_n), .I_RD_SEL(rd_sel),
    .O_DB(o_db), .O_INT_N(o_int_n), .I_DAC(dac), .O_DAC(o_dac)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_update();
    bit pop_ev, do_pop, set_ovf;
    int age;
    if (!rst) begin
      q.delete();
      m_ovf = 0; m_full = 0; m_int_n = 1; m_db = 8'h00; m_dac = 0;
      m_trig_n = 3'b111; prev_rd_n = 1; prev_trig = 3'b000;
      for (int i = 0; i < 3; i++) last_rise[i] = -1000;
    end else begin
      if (rd_sel && !rd_n) m_db = (q.size() == 0) ? 8'h0F : {4'h0, ~q[0]};
      else                 m_db = 8'h00;
      pop_ev  = !prev_rd_n && rd_n && rd_sel;
      do_pop  = pop_ev && (q.size() > 0);
      set_ovf = we && (q.size() == 4) && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (we && !set_ovf) q.push_back(cmd);
      if (set_ovf) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_full  = (q.size() == 4);
      m_int_n = (q.size() == 0);
      for (int i = 0; i < 3; i++) begin
        age = cyc - last_rise[i];
        m_trig_n[i] = !(trig[i] || (age >= 1 && age <= 16));
        if (trig[i] && !prev_trig[i]) last_rise[i] = cyc;
      end
`ifdef DKONG_SND_DAC_SLEW_EN
      if (int'(dac) > m_dac)      m_dac = (int'(dac) - m_dac <= 4) ? int'(dac) : m_dac + 4;
      else if (int'(dac) < m_dac) m_dac = (m_dac - int'(dac) <= 4) ? int'(dac) : m_dac - 4;
`else
      m_dac = int'(dac);
`endif
      prev_rd_n = rd_n;
      prev_trig = trig;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("model_int_n", 32'(o_int_n), 32'(m_int_n));
    chk("model_full",  32'(o_full),  32'(m_full));
    chk("model_ovf",   32'(o_ovf),   32'(m_ovf));
    chk("model_db",    32'(o_db),    32'(m_db));
    chk("model_trig_n", 32'(o_trig_n), 32'(m_trig_n));
    chk("model_dac",   32'(o_dac),   32'(m_dac));
  endtask

  task automatic push(input logic [3:0] v);
    cmd = v; we = 1; tick(); we = 0;
  endtask

  // Selected read: returns the bus value during the low phase, then pops on release.
  task automatic read_pop(output logic [7:0] v);
    rd_sel = 1; rd_n = 0; tick(); v = o_db;
    rd_n = 1; tick(); rd_sel = 0;
  endtask

  initial begin
    logic [7:0] v;
    int low;
    rst = 0; cmd = 0; we = 0; ovf_clr = 0; trig = 0; rd_n = 1; rd_sel = 0; dac = 0;
    tick(); tick();
    chk("rst_int_n", 32'(o_int_n), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);
    chk("rst_trig_n", 32'(o_trig_n), 32'h7);
    chk("rst_db", 32'(o_db), 32'd0);
    chk("rst_dac", 32'(o_dac), 32'd0);
    rst = 1; tick();

    // 1: two commands, read back inverted, interrupt follows occupancy
    push(4'h3);
    chk("t1_int_after_push", 32'(o_int_n), 32'd0);
    push(4'hA);
    read_pop(v); chk("t1_db_first", 32'(v), 32'h0C);
    read_pop(v); chk("t1_db_second", 32'(v), 32'h05);
    chk("t1_int_empty", 32'(o_int_n), 32'd1);

    // 2: overflow on the fifth push, set beats clear, clear, readout without the dropped value
    for (int i = 1; i <= 5; i++) begin
      cmd = 4'(i); we = 1; tick();
      if (i == 4) chk("t2_full_4th", 32'(o_full), 32'd1);
      if (i == 4) chk("t2_no_ovf_4th", 32'(o_ovf), 32'd0);
    end
    we = 0;
    chk("t2_ovf_5th", 32'(o_ovf), 32'd1);
    cmd = 4'h7; we = 1; ovf_clr = 1; tick(); we = 0;
    chk("t2_set_beats_clr", 32'(o_ovf), 32'd1);
    tick(); ovf_clr = 0;
    chk("t2_ovf_cleared", 32'(o_ovf), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      read_pop(v); chk("t2_readout", 32'(v), 32'(8'(~4'(i)) & 8'h0F));
    end
    chk("t2_empty", 32'(o_int_n), 32'd1);

    // 3: push and pop in the same cycle while full
    for (int i = 6; i <= 9; i++) push(4'(i));
    rd_sel = 1; rd_n = 0; tick();
    chk("t3_head", 32'(o_db), 32'h09);
    rd_n = 1; cmd = 4'hE; we = 1; tick(); we = 0; rd_sel = 0;
    chk("t3_no_ovf", 32'(o_ovf), 32'd0);
    chk("t3_still_full", 32'(o_full), 32'd1);
    read_pop(v); chk("t3_r7", 32'(v), 32'h08);
    read_pop(v); chk("t3_r8", 32'(v), 32'h07);
    read_pop(v); chk("t3_r9", 32'(v), 32'h06);
    read_pop(v); chk("t3_new_last", 32'(v), 32'h01);

    // 5: empty read and deselected read
    rd_sel = 1; rd_n = 0; tick();
    chk("t5_empty_db", 32'(o_db), 32'h0F);
    rd_n = 1; tick();
    chk("t5_empty_int", 32'(o_int_n), 32'd1);
    push(4'h5);
    rd_sel = 0; rd_n = 0; tick();
    chk("t5_desel_db", 32'(o_db), 32'h00);
    rd_n = 1; tick();
    chk("t5_desel_nopop", 32'(o_int_n), 32'd0);
    read_pop(v); chk("t5_after_desel", 32'(v), 32'h0A);

    // 4: trigger stretch, single pulse then pulse re-armed at cycle 10
    for (int pass = 0; pass < 2; pass++) begin
      trig = 3'b010; tick();
      chk("t4_low_on_pulse", 32'(o_trig_n), 32'h5);
      low = 0;
      for (int i = 1; i <= 60; i++) begin
        trig = (pass == 1 && i == 10) ? 3'b010 : 3'b000;
        tick();
        if (o_trig_n[1] == 1'b0) low++;
        else break;
      end
      trig = 0;
      chk(pass == 0 ? "t4_stretch16" : "t4_stretch26", 32'(low), pass == 0 ? 32'd16 : 32'd26);
    end

    // 6: DAC path and reset mid-operation
    push(4'h1); push(4'h2);
    dac = 8'd0; tick();
    dac = 8'd10;
`ifdef DKONG_SND_DAC_SLEW_EN
    tick(); chk("t6_slew4", 32'(o_dac), 32'd4);
    tick(); chk("t6_slew8", 32'(o_dac), 32'd8);
    tick(); chk("t6_slew10", 32'(o_dac), 32'd10);
    tick(); chk("t6_hold10", 32'(o_dac), 32'd10);
    dac = 8'd200; tick(); tick();
    chk("t6_midramp", 32'(o_dac), 32'd18);
`else
    tick(); chk("t6_dac10", 32'(o_dac), 32'd10);
    dac = 8'd200; tick();
    chk("t6_dac200", 32'(o_dac), 32'd200);
`endif
    trig = 3'b001; tick(); trig = 0;
    rst = 0; tick();
    chk("t6_rst_dac", 32'(o_dac), 32'd0);
    chk("t6_rst_int", 32'(o_int_n), 32'd1);
    chk("t6_rst_trig", 32'(o_trig_n), 32'h7);
    chk("t6_rst_full", 32'(o_full), 32'd0);
    rst = 1; tick();
    rd_sel = 1; rd_n = 0; tick(); rd_n = 1; rd_sel = 0;
    chk("t6_discarded", 32'(o_db), 32'h0F);
    tick();

    // random phase against the model
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 79) != 0);
      we      = ($urandom_range(0, 1) == 1);
      cmd     = 4'($urandom);
      rd_n    = ($urandom_range(0, 1) == 1);
      rd_sel  = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 3; i++) trig[i] = ($urandom_range(0, 9) == 0);
      dac     = 8'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
